mem_bist_ctrl: RTL and testbench

// Initiator side of the single-port synchronous memory interface (data_in/address/wr/rd -> data_out).
// On start: writes every address with pattern (addr*MULT), reads all addresses back, compares each word.

---
 rtl/mem_bist_pkg.sv | 33 +++
 rtl/mem_bist_if.sv | 21 ++
 rtl/mem_bist_cmp_pipe.sv | 52 +++++
 rtl/mem_bist_ctrl.sv | 155 +++++++++++++++
 tb/tb_mem_bist_ctrl.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/mem_bist_pkg.sv
// rtl/mem_bist_pkg.sv - shared constants, FSM encoding and test pattern for the memory BIST
// Contents:
//   DW, AW, DEPTH, MULT, RD_LAT  memory geometry, pattern multiplier, read latency
//   bist_state_t                 controller FSM states
//   bist_pattern()               expected word for an address, (addr*MULT) mod 2**DW
package mem_bist_pkg;

   localparam int DW     = 8;
   localparam int AW     = 4;
   localparam int DEPTH  = 16;
   localparam int MULT   = 5;
   localparam int RD_LAT = 1;

   // Drain counter counts 0..RD_LAT-1; keep at least one bit.
   localparam int DRN_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WRITE,
      ST_READ,
      ST_DRAIN,
      ST_DONE
   } bist_state_t;

   // Product formed at DW+AW bits so nothing is lost before the
   // intentional wrap to DW bits.
   function automatic logic [DW-1:0] bist_pattern(input logic [AW-1:0] addr);
      logic [DW+AW-1:0] prod;
      prod = (DW+AW)'(addr) * (DW+AW)'(MULT);
      return prod[DW-1:0];
   endfunction

endpackage

// File: rtl/mem_bist_if.sv
// rtl/mem_bist_if.sv - single-port synchronous memory bus between BIST initiator and memory
// Signals:
//   data_in   DW  write data towards memory
//   address   AW  word address
//   wr        1   write strobe
//   rd        1   read strobe
//   data_out  DW  read data from memory
// Modports: master (BIST controller), slave (memory)
interface mem_bist_if;
   import mem_bist_pkg::*;

   logic [DW-1:0] data_in;
   logic [AW-1:0] address;
   logic          wr;
   logic          rd;
   logic [DW-1:0] data_out;

   modport master (output data_in, output address, output wr, output rd, input data_out);
   modport slave  (input data_in, input address, input wr, input rd, output data_out);

endinterface

// File: rtl/mem_bist_cmp_pipe.sv
// rtl/mem_bist_cmp_pipe.sv - read-latency delay line for expected data plus comparator
// Ports:
//   i_clk       clock
//   i_rst       synchronous reset, active-low
//   i_valid     a read is being issued this cycle
//   i_exp       expected word for that read
//   i_addr      address of that read
//   i_rdata     memory read data
//   o_mismatch  compare slot is valid and read data differs (combinational)
//   o_addr      address belonging to the current compare slot
module mem_bist_cmp_pipe
   import mem_bist_pkg::*;
(
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_valid,
   input  logic [DW-1:0] i_exp,
   input  logic [AW-1:0] i_addr,
   input  logic [DW-1:0] i_rdata,
   output logic          o_mismatch,
   output logic [AW-1:0] o_addr
);

   logic [RD_LAT-1:0] r_vld;
   logic [DW-1:0]     r_exp [RD_LAT];
   logic [AW-1:0]     r_adr [RD_LAT];

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         r_vld <= '0;
         for (int i = 0; i < RD_LAT; i++) begin
            r_exp[i] <= '0;
            r_adr[i] <= '0;
         end
      end else begin
         r_vld[0] <= i_valid;
         r_exp[0] <= i_exp;
         r_adr[0] <= i_addr;
         for (int i = 1; i < RD_LAT; i++) begin
            r_vld[i] <= r_vld[i-1];
            r_exp[i] <= r_exp[i-1];
            r_adr[i] <= r_adr[i-1];
         end
      end
   end

   // Read data is only looked at when the slot is valid, so X on the bus
   // outside compare slots cannot disturb the result.
   assign o_mismatch = r_vld[RD_LAT-1] && (i_rdata != r_exp[RD_LAT-1]);
   assign o_addr     = r_adr[RD_LAT-1];

endmodule

// File: rtl/mem_bist_ctrl.sv
// rtl/mem_bist_ctrl.sv - memory BIST controller: write pattern, read back, compare, report
// Ports:
//   i_clk               clock, all logic on posedge
//   i_rst               synchronous reset, active-low
//   i_start             begin test, honoured only in IDLE or DONE
//   mem_bus             memory bus (master side)
//   o_busy              high in WRITE, READ, DRAIN
//   o_done              high in DONE until next start or reset
//   o_pass              done with no mismatches
//   o_err_count         mismatch count, saturates at DEPTH
//   o_first_err_addr    address of first mismatch, 0 if none
module mem_bist_ctrl
   import mem_bist_pkg::*;
(
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_start,
   mem_bist_if.master        mem_bus,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_pass,
   output logic [AW:0]       o_err_count,
   output logic [AW-1:0]     o_first_err_addr
);

   localparam logic [AW-1:0]    LAST_ADDR  = AW'(DEPTH - 1);
   localparam logic [AW:0]      ERR_MAX    = (AW+1)'(DEPTH);
   localparam logic [DRN_W-1:0] DRAIN_LAST = DRN_W'(RD_LAT - 1);

   bist_state_t      r_state, w_state;
   logic [AW-1:0]    r_addr, w_addr;
   logic [DRN_W-1:0] r_drain, w_drain;
   logic             r_wr, w_wr;
   logic             r_rd, w_rd;
   logic [DW-1:0]    r_data, w_data;
   logic             r_busy, w_busy;
   logic             r_done, w_done;
   logic             r_pass, w_pass;
   logic [AW:0]      r_err, w_err;
   logic [AW-1:0]    r_first, w_first;

   logic             w_mismatch;
   logic [AW-1:0]    w_cmp_addr;
   logic [DW-1:0]    w_rd_exp;

   assign w_rd_exp = bist_pattern(r_addr);

   // r_rd/r_addr describe the read on the bus this cycle.
   mem_bist_cmp_pipe u_cmp (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_valid    (r_rd),
      .i_exp      (w_rd_exp),
      .i_addr     (r_addr),
      .i_rdata    (mem_bus.data_out),
      .o_mismatch (w_mismatch),
      .o_addr     (w_cmp_addr)
   );

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         r_state <= ST_IDLE;
         r_addr  <= '0;
         r_drain <= '0;
         r_wr    <= 1'b0;
         r_rd    <= 1'b0;
         r_data  <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_pass  <= 1'b0;
         r_err   <= '0;
         r_first <= '0;
      end else begin
         r_state <= w_state;
         r_addr  <= w_addr;
         r_drain <= w_drain;
         r_wr    <= w_wr;
         r_rd    <= w_rd;
         r_data  <= w_data;
         r_busy  <= w_busy;
         r_done  <= w_done;
         r_pass  <= w_pass;
         r_err   <= w_err;
         r_first <= w_first;
      end
   end

   always_comb begin
      w_state = r_state;
      w_addr  = r_addr;
      w_drain = r_drain;
      w_err   = r_err;
      w_first = r_first;

      if (w_mismatch) begin
         if (r_err != ERR_MAX) w_err = r_err + 1'b1;
         if (r_err == '0)      w_first = w_cmp_addr;
      end

      case (r_state)
         ST_IDLE, ST_DONE: begin
            if (i_start) begin
               w_state = ST_WRITE;
               w_addr  = '0;
               w_drain = '0;
               w_err   = '0;
               w_first = '0;
            end
         end
         ST_WRITE: begin
            if (r_addr == LAST_ADDR) begin
               w_state = ST_READ;
               w_addr  = '0;
            end else begin
               w_addr = r_addr + 1'b1;
            end
         end
         ST_READ: begin
            if (r_addr == LAST_ADDR) begin
               w_state = ST_DRAIN;
               w_addr  = '0;
               w_drain = '0;
            end else begin
               w_addr = r_addr + 1'b1;
            end
         end
         ST_DRAIN: begin
            // The final compare lands on the same edge that enters DONE.
            if (r_drain == DRAIN_LAST) w_state = ST_DONE;
            else                       w_drain = r_drain + 1'b1;
         end
         default: w_state = ST_IDLE;
      endcase

      // Outputs follow the state being entered so they are registered
      // yet line up with that state's cycle.
      w_wr   = (w_state == ST_WRITE);
      w_rd   = (w_state == ST_READ);
      w_data = w_wr ? bist_pattern(w_addr) : '0;
      w_busy = w_wr || w_rd || (w_state == ST_DRAIN);
      w_done = (w_state == ST_DONE);
      w_pass = w_done && (w_err == '0);
   end

   assign mem_bus.wr       = r_wr;
   assign mem_bus.rd       = r_rd;
   assign mem_bus.address  = r_addr;
   assign mem_bus.data_in  = r_data;
   assign o_busy           = r_busy;
   assign o_done           = r_done;
   assign o_pass           = r_pass;
   assign o_err_count      = r_err;
   assign o_first_err_addr = r_first;

endmodule

// File: tb/tb_mem_bist_ctrl.sv
// tb/tb_mem_bist_ctrl.sv - self-checking bench for mem_bist_ctrl with a behavioural faulty memory
module tb_mem_bist_ctrl;
   import mem_bist_pkg::*;

   localparam int LAST_K = 2*DEPTH + RD_LAT;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start = 1'b0;
   logic busy, done, pass;
   logic [AW:0]   err_count;
   logic [AW-1:0] first_err;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   mem_bist_if bus ();

   mem_bist_ctrl dut (
      .i_clk            (clk),
      .i_rst            (rst_n),
      .i_start          (start),
      .mem_bus          (bus),
      .o_busy           (busy),
      .o_done           (done),
      .o_pass           (pass),
      .o_err_count      (err_count),
      .o_first_err_addr (first_err)
   );

   // Behavioural 16x8 memory, 1-cycle registered read; faults injected on read.
   logic [DW-1:0] mem_arr [DEPTH];
   logic [DW-1:0] and_m   [DEPTH];
   logic [DW-1:0] xor_m   [DEPTH];
   logic [DW-1:0] rdata = '0;

   always @(posedge clk) begin
      if (bus.wr) mem_arr[bus.address] <= bus.data_in;
      if (bus.rd) rdata <= (mem_arr[bus.address] & and_m[bus.address]) ^ xor_m[bus.address];
   end
   assign bus.data_out = rdata;

   typedef struct {
      string         name;
      int            faddr;
      logic [DW-1:0] andm;
      logic [DW-1:0] xorm;
      bit            stuck;
      int            e_err;
      int            e_first;
      bit            e_pass;
   } vec_t;

   vec_t vecs [6];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // Reference: after a write pass every word holds addr*MULT mod 2**DW;
   // a read differs wherever the injected fault changes that word.
   task automatic model(output int e_err, output int e_first, output bit e_pass);
      e_err = 0;
      e_first = 0;
      for (int a = 0; a < DEPTH; a++) begin
         int want, got;
         want = (a * MULT) % (1 << DW);
         got  = (want & int'(and_m[a])) ^ int'(xor_m[a]);
         if (got != want) begin
            if (e_err == 0) e_first = a;
            e_err++;
         end
      end
      if (e_err > DEPTH) e_err = DEPTH;
      e_pass = (e_err == 0);
   endtask

   task automatic clean_mem_faults();
      for (int a = 0; a < DEPTH; a++) begin
         and_m[a] = '1;
         xor_m[a] = '0;
      end
   endtask

   // Entered just after a negedge with the DUT in IDLE or DONE.
   task automatic run(input int poke_k, input bit hold, input int e_err, input int e_first,
                      input bit e_pass, input string tag);
      start = 1'b1;
      for (int k = 0; k <= LAST_K; k++) begin
         bit e_wr, e_rd, e_busy, e_done;
         int e_addr, e_data;
         logic [15:0] act, exp;
         @(negedge clk);
         e_wr   = (k < DEPTH);
         e_rd   = (k >= DEPTH) && (k < 2*DEPTH);
         e_addr = e_wr ? k : (e_rd ? k - DEPTH : 0);
         e_data = e_wr ? (k * MULT) % (1 << DW) : 0;
         e_busy = (k < LAST_K);
         e_done = (k == LAST_K);
         act = {busy, done, bus.wr, bus.rd, bus.address, bus.data_in};
         exp = {e_busy, e_done, e_wr, e_rd, AW'(e_addr), DW'(e_data)};
         check($sformatf("%s seq k=%0d", tag, k), 64'(act), 64'(exp));
         if (k == 0) begin
            check({tag, " cleared"}, {err_count, first_err, pass}, '0);
         end
         if (k == LAST_K) begin
            check({tag, " err_count"}, 64'(err_count), 64'(e_err));
            check({tag, " first_err"}, 64'(first_err), 64'(e_first));
            check({tag, " pass"},      64'(pass),      64'(e_pass));
         end
         start = hold || (k == poke_k);
      end
   endtask

   task automatic wait_done(input string tag);
      for (int n = 0; n < 100 && !done; n++) @(negedge clk);
      check({tag, " done reached"}, 64'(done), 64'd1);
   endtask

   initial begin
      int e_err, e_first;
      bit e_pass;

      clean_mem_faults();
      for (int a = 0; a < DEPTH; a++) mem_arr[a] = '0;

      vecs[0] = '{"good",      -1, 8'hFF, 8'h00, 1'b0, 0,         0,  1'b1};
      vecs[1] = '{"a7_b0_sa0",  7, 8'hFE, 8'h00, 1'b0, 1,         7,  1'b0};
      vecs[2] = '{"stuck0",    -1, 8'hFF, 8'h00, 1'b1, DEPTH - 1, 1,  1'b0};
      vecs[3] = '{"a0_flip",    0, 8'hFF, 8'h80, 1'b0, 1,         0,  1'b0};
      vecs[4] = '{"a15_flip",  15, 8'hFF, 8'h01, 1'b0, 1,         15, 1'b0};
      vecs[5] = '{"good2",     -1, 8'hFF, 8'h00, 1'b0, 0,         0,  1'b1};

      // Reset held for two edges with start high.
      rst_n = 1'b0;
      start = 1'b1;
      repeat (2) @(negedge clk);
      check("reset outs", {busy, done, pass, err_count, first_err}, '0);
      check("reset bus", {bus.wr, bus.rd, bus.address, bus.data_in}, '0);
      start = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);
      check("idle after reset", {busy, done, bus.wr, bus.rd}, '0);

      foreach (vecs[i]) begin
         for (int a = 0; a < DEPTH; a++) begin
            and_m[a] = vecs[i].stuck ? '0 : ((a == vecs[i].faddr) ? vecs[i].andm : '1);
            xor_m[a] = (a == vecs[i].faddr) ? vecs[i].xorm : '0;
         end
         run(-1, 1'b0, vecs[i].e_err, vecs[i].e_first, vecs[i].e_pass, vecs[i].name);
      end

      // start pulse in the middle of a run is ignored.
      clean_mem_faults();
      run(10, 1'b0, 0, 0, 1'b1, "poke");

      // start held high: next run begins only once DONE is reached.
      run(-1, 1'b1, 0, 0, 1'b1, "hold");
      @(negedge clk);
      check("hold restart", {done, busy, bus.wr, bus.address}, {1'b0, 1'b1, 1'b1, AW'(0)});
      start = 1'b0;
      wait_done("hold2");
      check("hold2 result", {pass, err_count}, {1'b1, (AW+1)'(0)});

      // Reset in the middle of the write phase.
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int n = 0; n < 20 && bus.address != AW'(9); n++) @(negedge clk);
      check("reached addr 9", {bus.wr, bus.address}, {1'b1, AW'(9)});
      rst_n = 1'b0;
      @(negedge clk);
      check("mid-write reset", {busy, done, pass, bus.wr, bus.rd, bus.address, bus.data_in}, '0);
      rst_n = 1'b1;
      @(negedge clk);
      run(-1, 1'b0, 0, 0, 1'b1, "after_rst");

      // Random read-fault maps against the reference model.
      for (int r = 0; r < 20; r++) begin
         for (int a = 0; a < DEPTH; a++) begin
            and_m[a] = '1;
            xor_m[a] = ($urandom_range(0, 3) == 0) ? DW'($urandom_range(1, 255)) : '0;
         end
         model(e_err, e_first, e_pass);
         run(-1, 1'b0, e_err, e_first, e_pass, $sformatf("rnd%0d", r));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
